operand_fetch: RTL and testbench

//  Register-read stage directly upstream of the 32-bit register file: drives its read

---
 rtl/operand_fetch.sv | 140 ++++++++++++++
 tb/tb_operand_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Register-read stage: drives register-file read addresses and bypasses the same-cycle write-back value.
// Tracks in-flight destinations in a pending scoreboard and holds the captured operands in one output slot.
module operand_fetch #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RWIDTH-1:0] in_ra1,
  input  logic [RWIDTH-1:0] in_ra2,
  input  logic [RWIDTH-1:0] in_wa,
  input  logic              in_we,
  input  logic [CWIDTH-1:0] in_ctrl,
  output logic [RWIDTH-1:0] rf_ra1,
  output logic [RWIDTH-1:0] rf_ra2,
  input  logic [DWIDTH-1:0] rf_rd1,
  input  logic [DWIDTH-1:0] rf_rd2,
  input  logic              wb_we,
  input  logic [RWIDTH-1:0] wb_wa,
  input  logic [DWIDTH-1:0] wb_wd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_op1,
  output logic [DWIDTH-1:0] out_op2,
  output logic [RWIDTH-1:0] out_wa,
  output logic              out_we,
  output logic [CWIDTH-1:0] out_ctrl
);

  localparam int NREG = 2 ** RWIDTH;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_reg;
  logic [NREG-1:0]     pending_reg;
  logic [NREG-1:0]     pending_next;
  logic [DWIDTH-1:0]   op1_reg;
  logic [DWIDTH-1:0]   op2_reg;
  logic [RWIDTH-1:0]   wa_reg;
  logic                we_reg;
  logic [CWIDTH-1:0]   ctrl_reg;

  logic [RWIDTH-1:0]   src_addr [3];
  logic [DWIDTH-1:0]   rf_data  [2];
  logic [DWIDTH-1:0]   op_sel   [2];
  logic [2:0]          wb_hit;
  logic [2:0]          blocked;
  logic                hazard;
  logic                accept;

  assign rf_ra1 = in_ra1;
  assign rf_ra2 = in_ra2;

  assign src_addr[0] = in_ra1;
  assign src_addr[1] = in_ra2;
  assign src_addr[2] = in_wa;
  assign rf_data[0]  = rf_rd1;
  assign rf_data[1]  = rf_rd2;

  // Entries 0/1 are the sources, entry 2 is the destination (WAW check).
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hit
      assign wb_hit[gi]  = wb_we && (wb_wa == src_addr[gi]) && (src_addr[gi] != '0);
      assign blocked[gi] = pending_reg[src_addr[gi]] && !wb_hit[gi];
    end
    for (gi = 0; gi < 2; gi++) begin : g_sel
      assign op_sel[gi] = (src_addr[gi] == '0) ? '0 :
                          wb_hit[gi]            ? wb_wd : rf_data[gi];
    end
  endgenerate

  assign hazard   = blocked[0] || blocked[1] || (in_we && (in_wa != '0) && blocked[2]);
  assign in_ready = ((state_reg == EMPTY) || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // A set on the same edge as a clear wins, so a re-issued destination stays pending.
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_bit
        assign pending_next[gi] =
          (accept && in_we && (in_wa == RWIDTH'(gi))) ||
          (pending_reg[gi] && !(wb_we && (wb_wa == RWIDTH'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      op1_reg   <= '0;
      op2_reg   <= '0;
      wa_reg    <= '0;
      we_reg    <= 1'b0;
      ctrl_reg  <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_reg <= FULL;
          end
        end
        FULL: begin
          if (!accept && out_ready) begin
            state_reg <= EMPTY;
          end
        end
        default: state_reg <= EMPTY;
      endcase
      if (accept) begin
        op1_reg  <= op_sel[0];
        op2_reg  <= op_sel[1];
        wa_reg   <= in_wa;
        we_reg   <= in_we;
        ctrl_reg <= in_ctrl;
      end
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_op1   = op1_reg;
  assign out_op2   = op2_reg;
  assign out_wa    = wa_reg;
  assign out_we    = we_reg;
  assign out_ctrl  = ctrl_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and randomized bench for operand_fetch against a scoreboard-level reference model.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_ra1, in_ra2, in_wa;
  logic        in_we;
  logic [15:0] in_ctrl;
  logic [5:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [5:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1, out_op2;
  logic [5:0]  out_wa;
  logic        out_we;
  logic [15:0] out_ctrl;

  int checks = 0;
  int errors = 0;

  // Architectural register file seen by the stage (combinational read).
  logic [31:0] regs [64];
  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];

  // Reference model: set of in-flight destinations plus the expected slot.
  bit [63:0]   m_pend;
  bit          m_valid;
  logic [31:0] m_op1, m_op2;
  logic [5:0]  m_wa;
  logic        m_we;
  logic [15:0] m_ctrl;
  bit          last_acc;

  operand_fetch #(.RWIDTH(6), .DWIDTH(32), .CWIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra1(in_ra1), .in_ra2(in_ra2), .in_wa(in_wa), .in_we(in_we), .in_ctrl(in_ctrl),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_wa(out_wa), .out_we(out_we), .out_ctrl(out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A register read is blocked while an earlier writer is outstanding, unless it lands now.
  function automatic bit waits_on(input logic [5:0] a);
    return m_pend[a] && !(wb_we && wb_wa == a);
  endfunction

  function automatic logic [31:0] fetch(input logic [5:0] a);
    if (a == 0) return 32'h0;
    if (wb_we && wb_wa == a) return wb_wd;
    return regs[a];
  endfunction

  task automatic drive(input bit v, input logic [5:0] a1, input logic [5:0] a2,
                       input logic [5:0] wa, input bit we, input logic [15:0] c,
                       input bit ordy, input bit wbe, input logic [5:0] wba,
                       input logic [31:0] wbd);
    in_valid = v; in_ra1 = a1; in_ra2 = a2; in_wa = wa; in_we = we; in_ctrl = c;
    out_ready = ordy; wb_we = wbe; wb_wa = wba; wb_wd = wbd;
  endtask

  task automatic check_slot();
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_op1", out_op1, m_op1);
      chk("out_op2", out_op2, m_op2);
      chk("out_wa", out_wa, m_wa);
      chk("out_we", out_we, m_we);
      chk("out_ctrl", out_ctrl, m_ctrl);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_valid = 0; m_op1 = 0; m_op2 = 0; m_wa = 0; m_we = 0; m_ctrl = 0;
  endtask

  task automatic step();
    bit exp_ready, acc;
    logic [31:0] v1, v2;
    @(negedge clk);
    exp_ready = (!m_valid || out_ready) && !waits_on(in_ra1) && !waits_on(in_ra2) &&
                !(in_we && in_wa != 0 && waits_on(in_wa));
    chk("in_ready", in_ready, exp_ready);
    chk("rf_ra1", rf_ra1, in_ra1);
    chk("rf_ra2", rf_ra2, in_ra2);
    acc = in_valid && exp_ready;
    v1 = fetch(in_ra1);
    v2 = fetch(in_ra2);
    @(posedge clk);
    #1;
    if (wb_we && wb_wa != 0) regs[wb_wa] = wb_wd;
    if (wb_we) m_pend[wb_wa] = 0;
    if (acc) begin
      if (in_we && in_wa != 0) m_pend[in_wa] = 1;
      m_valid = 1; m_op1 = v1; m_op2 = v2; m_wa = in_wa; m_we = in_we; m_ctrl = in_ctrl;
      $display("txn ra1=%0d ra2=%0d wa=%0d we=%0d op1=%h op2=%h ctrl=%h",
               in_ra1, in_ra2, in_wa, in_we, v1, v2, in_ctrl);
    end else if (out_ready) begin
      m_valid = 0;
    end
    last_acc = acc;
    check_slot();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = $urandom;
    regs[0] = 32'hFFFF_FFFF;
    regs[3] = 32'h11;
    regs[4] = 32'h22;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #12;
    rst = 1'b0;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_op1", out_op1, 32'h0);
    chk("rst_op2", out_op2, 32'h0);
    chk("rst_wa", out_wa, 6'd0);
    chk("rst_we", out_we, 1'b0);
    chk("rst_ctrl", out_ctrl, 16'h0);

    // 1: simple issue and back-to-back independent instructions
    drive(1, 3, 4, 0, 0, 16'h0001, 1, 0, 0, 0);
    step();
    chk("t1_op1", out_op1, 32'h11);
    chk("t1_op2", out_op2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      drive(1, 4, 3, 6'(20 + i), 0, 16'(i + 2), 1, 0, 0, 0);
      step();
      chk("t1_b2b", last_acc, in_ready);
    end

    // 2: RAW stall then write-back bypass
    drive(1, 1, 2, 5, 1, 16'h0200, 1, 0, 0, 0);
    step();
    drive(1, 5, 2, 0, 0, 16'h0201, 1, 0, 0, 0);
    step();
    chk("t2_stall", in_ready, 1'b0);
    drive(1, 5, 2, 0, 0, 16'h0202, 1, 1, 5, 32'hDEAD);
    step();
    chk("t2_bypass", out_op1, 32'hDEAD);
    drive(1, 5, 5, 0, 0, 16'h0203, 1, 0, 0, 0);
    step();
    chk("t2_cleared", out_op2, 32'hDEAD);

    // 3: register 0 reads zero regardless of rf data or write-back
    drive(1, 0, 0, 0, 1, 16'h0300, 1, 1, 0, 32'h1234_5678);
    step();
    chk("t3_op1", out_op1, 32'h0);
    chk("t3_op2", out_op2, 32'h0);
    chk("t3_we", out_we, 1'b1);

    // 4: backpressure holds slot, release replaces it on the same edge
    drive(1, 3, 4, 10, 0, 16'hAAAA, 1, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 4, 3, 11, 0, 16'hBBBB, 0, 0, 0, 0);
      step();
      chk("t4_hold", out_ctrl, 16'hAAAA);
    end
    drive(1, 4, 3, 11, 0, 16'hBBBB, 1, 0, 0, 0);
    step();
    chk("t4_replace", out_ctrl, 16'hBBBB);

    // 5: clear and set of r7 on one edge leaves it pending
    drive(1, 1, 2, 7, 1, 16'h0500, 1, 0, 0, 0);
    step();
    drive(1, 1, 2, 7, 1, 16'h0501, 1, 1, 7, 32'h7777);
    step();
    chk("t5_reissue", out_ctrl, 16'h0501);
    drive(1, 7, 1, 0, 0, 16'h0502, 1, 0, 0, 0);
    step();
    step();
    chk("t5_stall", in_ready, 1'b0);
    drive(1, 7, 1, 0, 0, 16'h0503, 1, 1, 7, 32'h7070);
    step();
    chk("t5_bypass", out_op1, 32'h7070);

    // 6: asynchronous reset while full with r9 pending
    drive(1, 1, 2, 9, 1, 16'h0600, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_op1", out_op1, 32'h0);
    chk("t6_op2", out_op2, 32'h0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    drive(1, 9, 9, 0, 0, 16'h0601, 1, 0, 0, 0);
    step();
    chk("t6_issue", out_valid, 1'b1);

    // randomized traffic on a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            6'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, 16'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, 6'($urandom_range(0, 7)),
            $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
